xform_arbiter: RTL and testbench
================================

Name: xform_arbiter

Overview:
- Round-robin arbiter sharing one pass/invert transform datapath (out = A or ~A, registered) among NREQ requesters.
- Each requester supplies an operand and a mode bit. The block grants one request per cycle, performs the transform, and returns the result with the requester ID through a single-entry output register with valid/ready backpressure.
- Sits between client blocks and the shared transform resource, replacing the free-running state-based mode selection with per-request mode.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 32, operand/result width.
- IDW, clog2(NREQ) (min 1), width of requester ID. Derived; not overridden.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_data  input  NREQ*DW  operands, requester i at bits [i*DW +: DW].
- req_mode  input  NREQ  per-requester mode: 1 = pass (out = A), 0 = invert (out = ~A).
- resp_valid  output  1  result register holds valid data.
- resp_ready  input  1  downstream accepts the result.
- resp_data  output  DW  transformed result.
- resp_id  output  IDW  index of the requester that produced resp_data.
- busy  output  1  equals resp_valid.

Behaviour:
- Reset: resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0 (requester 0 highest priority). req_ready=0 during reset. Reset mid-transaction discards a held result without handshake.
- Output FSM, 2 states:
  - EMPTY (resp_valid=0) -> FULL on accept.
  - FULL -> EMPTY when resp_ready and no accept in the same cycle.
  - FULL -> FULL when resp_ready and accept in the same cycle (back-to-back), or when !resp_ready (hold).
- can_accept = !resp_valid | resp_ready.
- Grant (combinational): scan req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit is winner g. req_ready = onehot(g) & can_accept. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Accept = any req_valid & can_accept. On the accept edge:
  - resp_data <= req_mode[g] ? req_data[g] : ~req_data[g]
  - resp_id <= g
  - resp_valid <= 1
  - rr_ptr <= (g+1) mod NREQ
- Latency: request accepted at edge k appears on resp_* after edge k; one cycle, no bubble under continuous resp_ready. Throughput is 1 result per cycle.
- Hold: while resp_valid & !resp_ready, resp_data and resp_id are stable and req_ready=0.
- rr_ptr changes only on accept. No valid requests leaves rr_ptr unchanged.
- Wrap: winner NREQ-1 sets rr_ptr to 0.
- Requester contract: once asserted, req_valid, req_data and req_mode stay stable until accepted. The arbiter does not check this.
- Fairness: a continuously valid requester is granted within NREQ accepts.

Decomposition:
- Shared package xform_pkg:
  - MODE_PASS=1'b1, MODE_INV=1'b0.
  - clog2 function for IDW.
  - FSM state encoding ST_EMPTY/ST_FULL.
- One natural sub-module: rr_picker (combinational rotating priority encoder: req vector + pointer -> one-hot grant + index + any). The transform and output register stay in xform_arbiter.

Test Plan:
1. Reset: assert rst 2 cycles with all req_valid=1. Expect req_ready=0, resp_valid=0, resp_data=0, resp_id=0. Release; first grant goes to requester 0.
2. Single request: req 2 valid, data 0x12345678, mode INV, resp_ready=1. Expect req_ready=4'b0100 in that cycle; next cycle resp_valid=1, resp_data=0xEDCBA987, resp_id=2.
3. Round-robin: all 4 valid continuously (mode PASS, data=i), resp_ready=1. Expect resp_id sequence 0,1,2,3,0,1 on consecutive cycles, resp_data equal to the ID.
4. Backpressure: req 1 accepted, resp_ready=0 for 3 cycles while req 3 is valid. Expect resp held (id 1) and req_ready=0. On the resp_ready=1 cycle, req 3 is accepted the same cycle; the next cycle shows resp_id=3.
5. Pointer wrap/skip: rr_ptr=3 after a grant to 2; only reqs 0 and 1 valid. Expect grant 0, then 1, then rr_ptr=2.
6. Reset mid-hold: resp_valid=1, resp_ready=0, assert rst. Next cycle resp_valid=0, rr_ptr=0, and the held result is lost.

Source files
------------

// File: rtl/xform_pkg.sv
// Shared definitions for the transform arbiter: mode encodings, output FSM states
// and the width helper used to size requester IDs.
package xform_pkg;

  localparam logic MODE_PASS = 1'b1;
  localparam logic MODE_INV  = 1'b0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Ceiling log2 with a floor of 1 so a 2-requester arbiter still gets a 1-bit ID.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/xform_arbiter_rr_picker.sv
// Rotating-priority encoder: the first set request at or after ptr (wrapping) wins.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int c;
    c   = 0;
    idx = '0;
    any = |req;
    // Scan from the farthest offset back to ptr so the nearest set bit is the last write.
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NREQ;
      if (req[c]) idx = IDW'(c);
    end
    gnt = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/xform_arbiter.sv
// Round-robin arbiter in front of a shared pass/invert transform with a single-entry
// valid/ready result register.
module xform_arbiter
  import xform_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = 32,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_mode,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DW-1:0]        resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  logic [NREQ-1:0][DW-1:0] data_arr;
  logic [NREQ-1:0]         gnt;
  logic [IDW-1:0]          g_idx;
  logic                    g_any;
  logic                    can_accept;
  logic                    accept;
  logic [DW-1:0]           operand;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [DW-1:0]  resp_data_q, resp_data_d;

  assign data_arr = req_data;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (g_idx),
    .any (g_any)
  );

  always_comb begin
    can_accept  = (state_q == ST_EMPTY) | resp_ready;
    accept      = g_any & can_accept & ~rst;
    req_ready   = accept ? gnt : '0;
    operand     = data_arr[g_idx];
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (resp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (accept) begin
      resp_data_d = (req_mode[g_idx] == MODE_PASS) ? operand : ~operand;
      resp_id_d   = g_idx;
      rr_ptr_d    = (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + IDW'(1);
    end
  end

  // Reset drops any held result; downstream never sees a handshake for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rr_ptr_q    <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign busy       = resp_valid;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_xform_arbiter.sv
// Directed vector bench for xform_arbiter (NREQ=4, DW=32); requester i drives data d+i.
module tb_xform_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_mode;
  logic                resp_valid;
  logic                resp_ready;
  logic [DW-1:0]       resp_data;
  logic [1:0]          resp_id;
  logic                busy;

  int n_chk;
  int n_fail;

  xform_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_mode   (req_mode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  mode;
    logic [31:0] d;
    logic        rr;
    logic [3:0]  rdy;
    logic        vld;
    logic [31:0] data;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic r, logic [3:0] rv, logic [3:0] mode, logic [31:0] d,
                              logic rr, logic [3:0] rdy, logic vld, logic [31:0] data,
                              logic [1:0] id);
    vec_t v;
    v.rst = r; v.rv = rv; v.mode = mode; v.d = d; v.rr = rr;
    v.rdy = rdy; v.vld = vld; v.data = data; v.id = id;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rv, input logic [3:0] mode,
                       input logic [31:0] d, input logic rr);
    rst        = r;
    req_valid  = rv;
    req_mode   = mode;
    resp_ready = rr;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = d + 32'(i);
  endtask

  // Inputs change 1ns after an edge; ready is checked just before the next edge,
  // registered outputs 1ns after it.
  task automatic step(input string tag, input logic [3:0] exp_rdy, input logic exp_vld,
                      input logic [31:0] exp_data, input logic [1:0] exp_id);
    #3;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'(exp_vld));
    chk({tag, " busy"}, 32'(busy), 32'(exp_vld));
    chk({tag, " resp_data"}, resp_data, exp_data);
    chk({tag, " resp_id"}, 32'(resp_id), 32'(exp_id));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //             rst rv     mode   d             rr    rdy    vld data          id
    tbl[0]  = mk(1, 4'hF, 4'hF, 32'h0,        1, 4'h0, 0, 32'h0,        0); // reset
    tbl[1]  = mk(1, 4'hF, 4'hF, 32'h0,        1, 4'h0, 0, 32'h0,        0);
    tbl[2]  = mk(0, 4'hF, 4'hF, 32'h100,      1, 4'h1, 1, 32'h100,      0); // first grant -> 0
    tbl[3]  = mk(0, 4'h0, 4'hF, 32'h100,      1, 4'h0, 0, 32'h100,      0); // drain
    tbl[4]  = mk(0, 4'h4, 4'h0, 32'h12345676, 1, 4'h4, 1, 32'hEDCBA987, 2); // single INV
    tbl[5]  = mk(1, 4'h0, 4'hF, 32'h0,        1, 4'h0, 0, 32'h0,        0); // ptr back to 0
    tbl[6]  = mk(0, 4'hF, 4'hF, 32'h0,        1, 4'h1, 1, 32'h0,        0); // round robin
    tbl[7]  = mk(0, 4'hF, 4'hF, 32'h0,        1, 4'h2, 1, 32'h1,        1);
    tbl[8]  = mk(0, 4'hF, 4'hF, 32'h0,        1, 4'h4, 1, 32'h2,        2);
    tbl[9]  = mk(0, 4'hF, 4'hF, 32'h0,        1, 4'h8, 1, 32'h3,        3);
    tbl[10] = mk(0, 4'hF, 4'hF, 32'h0,        1, 4'h1, 1, 32'h0,        0);
    tbl[11] = mk(0, 4'hF, 4'hF, 32'h0,        1, 4'h2, 1, 32'h1,        1);
    tbl[12] = mk(0, 4'h2, 4'hF, 32'h200,      1, 4'h2, 1, 32'h201,      1); // ptr=2, only req1
    tbl[13] = mk(0, 4'h8, 4'hF, 32'h200,      0, 4'h0, 1, 32'h201,      1); // hold x3
    tbl[14] = mk(0, 4'h8, 4'hF, 32'h200,      0, 4'h0, 1, 32'h201,      1);
    tbl[15] = mk(0, 4'h8, 4'hF, 32'h200,      0, 4'h0, 1, 32'h201,      1);
    tbl[16] = mk(0, 4'h8, 4'hF, 32'h200,      1, 4'h8, 1, 32'h203,      3); // back-to-back
    tbl[17] = mk(0, 4'h4, 4'hF, 32'h300,      1, 4'h4, 1, 32'h302,      2); // ptr -> 3
    tbl[18] = mk(0, 4'h3, 4'hF, 32'h300,      1, 4'h1, 1, 32'h300,      0); // wrap skip 3
    tbl[19] = mk(0, 4'h2, 4'hF, 32'h300,      1, 4'h2, 1, 32'h301,      1);
    tbl[20] = mk(0, 4'hF, 4'h0, 32'h300,      1, 4'h4, 1, 32'hFFFFFCFD, 2); // ptr was 2

    drive(1, 4'h0, 4'h0, 32'h0, 0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 21; r++) begin
      drive(tbl[r].rst, tbl[r].rv, tbl[r].mode, tbl[r].d, tbl[r].rr);
      step($sformatf("vec%0d", r), tbl[r].rdy, tbl[r].vld, tbl[r].data, tbl[r].id);
    end

    // Reset while a result is held: ptr was 3, req 1 wins and moves it to 2.
    drive(0, 4'h2, 4'hF, 32'h500, 1);
    step("mid grant", 4'h2, 1, 32'h501, 1);
    drive(0, 4'h0, 4'hF, 32'h500, 0);
    step("mid hold", 4'h0, 1, 32'h501, 1);
    drive(1, 4'hF, 4'hF, 32'h500, 0);
    step("mid reset", 4'h0, 0, 32'h0, 0);
    drive(0, 4'hF, 4'hF, 32'h600, 1);
    step("post reset ptr", 4'h1, 1, 32'h600, 0);

    // Fairness: with all valid under backpressure pulses, each ID appears within 4 accepts.
    begin
      logic [3:0] seen;
      seen = 4'h0;
      for (int c = 0; c < 8; c++) begin
        drive(0, 4'hF, 4'hF, 32'h700, c[0]);
        #3;
        @(posedge clk);
        #1;
        if (c[0]) seen[resp_id] = 1'b1;
      end
      chk("fairness ids seen", 32'(seen), 32'hF);
    end

    drive(0, 4'h0, 4'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
